// File: rtl/aes_decrypt.sv
// Iterative AES-128 decryption core, one round per clock.
// Expands the cipher key forward to rk10, then walks the key schedule backward while decrypting.
module aes_decrypt (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] ciphertext,
  input  logic [127:0] key,
  output logic [127:0] plaintext,
  output logic         done,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, EXPAND, ARK0, ROUND} state_e;

  state_e       fsm_q, fsm_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] key_q, key_d;
  logic [127:0] data_q, data_d;
  logic [127:0] pt_q, pt_d;
  logic         done_q, done_d;
  logic         busy_q, busy_d;

  logic [31:0]  kw0, kw1, kw2, kw3;
  logic [31:0]  sw_in, sw_out;
  logic [31:0]  w0n, w1n, w2n, w3n;
  logic [7:0]   rc;
  logic [127:0] key_fwd, key_inv, round_sub, round_out;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0, as the S-box needs.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq, acc;
    sq  = a;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] a);
    logic [7:0] t;
    t = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    return gf_inv(t);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_fwd(w[31:24]), sbox_fwd(w[23:16]), sbox_fwd(w[15:8]), sbox_fwd(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Byte (row r, column c) lives at index 4c+r; InvShiftRows pulls from column c-r.
  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = sbox_inv(s[127-8*(4*((c-r+4)%4)+r) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 32] = {
        gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
        gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
        gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
        gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    end
    return o;
  endfunction

  // One SubWord serves both directions: forward uses w3, backward uses the recovered w3' = w3 ^ w2.
  always_comb begin
    kw0 = key_q[127:96];
    kw1 = key_q[95:64];
    kw2 = key_q[63:32];
    kw3 = key_q[31:0];
    if (fsm_q == EXPAND) begin
      sw_in = kw3;
      rc    = rcon(cnt_q + 4'd1);
    end else begin
      sw_in = kw3 ^ kw2;
      rc    = rcon(cnt_q);
    end
    sw_out    = sub_word({sw_in[23:0], sw_in[31:24]});
    w0n       = kw0 ^ sw_out ^ {rc, 24'h000000};
    w1n       = kw1 ^ w0n;
    w2n       = kw2 ^ w1n;
    w3n       = kw3 ^ w2n;
    key_fwd   = {w0n, w1n, w2n, w3n};
    key_inv   = {w0n, kw1 ^ kw0, kw2 ^ kw1, kw3 ^ kw2};
    round_sub = inv_shift_sub(data_q) ^ key_q;
    round_out = (cnt_q == 4'd0) ? round_sub : inv_mix(round_sub);
  end

  always_comb begin
    fsm_d  = fsm_q;
    cnt_d  = cnt_q;
    key_d  = key_q;
    data_d = data_q;
    pt_d   = pt_q;
    done_d = 1'b0;
    busy_d = busy_q;
    case (fsm_q)
      IDLE: begin
        if (start) begin
          data_d = ciphertext;
          key_d  = key;
          cnt_d  = 4'd0;
          busy_d = 1'b1;
          fsm_d  = EXPAND;
        end
      end
      EXPAND: begin
        key_d = key_fwd;
        if (cnt_q != 4'd10) cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd9) fsm_d = ARK0;
      end
      ARK0: begin
        data_d = data_q ^ key_q;
        key_d  = key_inv;
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        fsm_d  = ROUND;
      end
      ROUND: begin
        data_d = round_out;
        key_d  = key_inv;
        if (cnt_q == 4'd0) begin
          pt_d   = round_out;
          done_d = 1'b1;
          busy_d = 1'b0;
          fsm_d  = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q  <= IDLE;
      cnt_q  <= 4'd0;
      key_q  <= '0;
      data_q <= '0;
      pt_q   <= '0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      cnt_q  <= cnt_d;
      key_q  <= key_d;
      data_q <= data_d;
      pt_q   <= pt_d;
      done_q <= done_d;
      busy_q <= busy_d;
    end
  end

  assign plaintext = pt_q;
  assign done      = done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_aes_decrypt.sv
// Self-checking bench for aes_decrypt: FIPS vectors, round trips through a reference
// encryptor, and the start-while-busy, mid-operation reset and output-hold sequences.
module tb_aes_decrypt;

  localparam int NVEC = 102;

  typedef struct {
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] ciphertext;
  logic [127:0] key;
  logic [127:0] plaintext;
  logic         done;
  logic         busy;

  logic [127:0] expPt;
  logic         checkOn;
  int           tests;
  int           fails;
  int           mdlCnt;
  logic [127:0] mdlPt;
  logic [127:0] scoreQ[$];
  logic [7:0]   sbox[256];
  vec_t         vecs[NVEC];

  aes_decrypt dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .ciphertext(ciphertext),
    .key       (key),
    .plaintext (plaintext),
    .done      (done),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Table built by brute-force inverse search followed by the forward affine map.
  task automatic buildSbox();
    logic [7:0] xb, yb, inv;
    for (int x = 0; x < 256; x++) begin
      xb  = 8'(x);
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        yb = 8'(y);
        if (gmul(xb, yb) == 8'h01) inv = yb;
      end
      sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aesEncrypt(input logic [127:0] k, input logic [127:0] p);
    logic [127:0] rk, s, t;
    logic [31:0]  w;
    logic [7:0]   rc, a0, a1, a2, a3;
    rk = k;
    s  = p ^ rk;
    rc = 8'h01;
    for (int rnd = 1; rnd <= 10; rnd++) begin
      w = rk[31:0];
      w = {sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]], sbox[w[31:24]]} ^ {rc, 24'h000000};
      rk[127:96] = rk[127:96] ^ w;
      rk[95:64]  = rk[95:64] ^ rk[127:96];
      rk[63:32]  = rk[63:32] ^ rk[95:64];
      rk[31:0]   = rk[31:0] ^ rk[63:32];
      rc = gmul(rc, 8'h02);
      t = '0;
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[127-8*(4*c+r) -: 8] = sbox[s[127-8*(4*((c+r)%4)+r) -: 8]];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[127-32*c -: 8];
          a1 = t[119-32*c -: 8];
          a2 = t[111-32*c -: 8];
          a3 = t[103-32*c -: 8];
          t[127-32*c -: 32] = {
            gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3,
            a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3,
            a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03),
            gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02)};
        end
      end
      s = t ^ rk;
    end
    return s;
  endfunction

  task automatic checkOutput(input string name, input int cyc, input logic [127:0] act,
                             input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [127:0] k, input logic [127:0] ct,
                               input logic [127:0] pt);
    @(negedge clk);
    key        = k;
    ciphertext = ct;
    expPt      = pt;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (22) @(negedge clk);
  endtask

  // Reference timing model: accept in idle, done 21 edges later, re-accept on the done edge.
  initial begin
    mdlCnt = 0;
    mdlPt  = '0;
    forever begin
      @(posedge clk);
      if (rst) begin
        mdlCnt = 0;
        mdlPt  = '0;
        scoreQ.delete();
      end else if (mdlCnt > 1) begin
        mdlCnt--;
        if (mdlCnt == 1 && scoreQ.size() > 0) mdlPt = scoreQ.pop_front();
      end else if (start) begin
        scoreQ.push_back(expPt);
        mdlCnt = 22;
      end else begin
        mdlCnt = 0;
      end
    end
  end

  // Every cycle, away from the active edge, compare all outputs against the model.
  initial begin
    int cyc;
    tests = 0;
    fails = 0;
    cyc   = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (checkOn) begin
        checkOutput("done", cyc, 128'(done), 128'(mdlCnt == 1));
        checkOutput("busy", cyc, 128'(busy), 128'(mdlCnt > 1));
        checkOutput("plaintext", cyc, plaintext, mdlPt);
      end
    end
  end

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    key        = '0;
    ciphertext = '0;
    expPt      = '0;
    checkOn    = 1'b0;
    buildSbox();
    vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                128'h00112233445566778899aabbccddeeff};
    vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3925841d02dc09fbdc118597196a0b32,
                128'h3243f6a8885a308d313198a2e0370734};
    for (int i = 2; i < NVEC; i++) begin
      vecs[i].key = {$urandom(), $urandom(), $urandom(), $urandom()};
      vecs[i].pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
      vecs[i].ct  = aesEncrypt(vecs[i].key, vecs[i].pt);
    end

    repeat (3) @(negedge clk);
    checkOn = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) applyStimulus(vecs[i].key, vecs[i].ct, vecs[i].pt);

    // start held for 100 edges; inputs swapped at E5 and again at E30
    @(negedge clk);
    key        = vecs[0].key;
    ciphertext = vecs[0].ct;
    expPt      = vecs[0].pt;
    start      = 1'b1;
    repeat (5) @(negedge clk);
    key        = vecs[1].key;
    ciphertext = vecs[1].ct;
    expPt      = vecs[1].pt;
    repeat (25) @(negedge clk);
    key        = vecs[2].key;
    ciphertext = vecs[2].ct;
    expPt      = vecs[2].pt;
    repeat (70) @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);

    // reset asserted for the E15 edge only
    @(negedge clk);
    key        = vecs[3].key;
    ciphertext = vecs[3].ct;
    expPt      = vecs[3].pt;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    applyStimulus(vecs[0].key, vecs[0].ct, vecs[0].pt);

    // inputs wiggle with start low; outputs must hold
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      key        = {$urandom(), $urandom(), $urandom(), $urandom()};
      ciphertext = {$urandom(), $urandom(), $urandom(), $urandom()};
    end
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
